// File: rtl/rca_seq_add_ctrl_pkg.sv
// Shared constants and FSM encoding for the multi-precision add/subtract sequencer.
package rca_seq_add_ctrl_pkg;

    // Width of one datapath word (the ripple-carry adder width).
    localparam int RCA_W = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca_seq_add_ctrl_if.sv
// Request/result bundle between the requesting unit and the sequencer.
interface rca_seq_add_ctrl_if
    import rca_seq_add_ctrl_pkg::*;
#(
    parameter int N_WORDS = 4
) ();

    logic                       start;
    logic                       sub;
    logic [RCA_W*N_WORDS-1:0]   a;
    logic [RCA_W*N_WORDS-1:0]   b;
    logic                       busy;
    logic                       done;
    logic [RCA_W*N_WORDS-1:0]   sum;
    logic                       c_out;
    logic                       ovf;

    // Requesting unit side.
    modport master (
        output start, sub, a, b,
        input  busy, done, sum, c_out, ovf
    );

    // Sequencer side.
    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, c_out, ovf
    );

endinterface

// File: rtl/rca_seq_add_ctrl_rca_16_bit.sv
// 16-bit ripple-carry adder: the single combinational datapath of the sequencer.
module rca_seq_add_ctrl_rca_16_bit
    import rca_seq_add_ctrl_pkg::*;
(
    input  logic [RCA_W-1:0] i_a,
    input  logic [RCA_W-1:0] i_b,
    input  logic             i_cin,
    output logic [RCA_W-1:0] o_sum,
    output logic             o_cout
);

    // Bit-serial full-adder chain, carry propagated LSB to MSB.
    always_comb begin
        logic w_carry;
        o_sum   = '0;
        w_carry = i_cin;
        for (int i = 0; i < RCA_W; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/rca_seq_add_ctrl.sv
// Multi-precision add/subtract sequencer: one 16-bit adder processes the
// operands one word per cycle, least-significant word first, with the
// inter-word carry held in a register.
module rca_seq_add_ctrl
    import rca_seq_add_ctrl_pkg::*;
#(
    parameter int N_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rca_seq_add_ctrl_if.slave    bus
);

    localparam int IDX_W = $clog2(N_WORDS);

    state_t                          r_state;
    state_t                          w_state_next;

    logic [N_WORDS-1:0][RCA_W-1:0]   r_a_q;
    logic [N_WORDS-1:0][RCA_W-1:0]   r_b_q;
    logic                            r_carry_q;
    logic [IDX_W-1:0]                r_idx;
    logic                            r_c_out;
    logic                            r_ovf;
    logic [N_WORDS-1:0][RCA_W-1:0]   w_sum_all;

    logic                            w_accept;
    logic                            w_run;
    logic                            w_last;
    logic                            w_busy;
    logic                            w_done;
    logic [RCA_W-1:0]                w_a_word;
    logic [RCA_W-1:0]                w_b_word;
    logic [RCA_W-1:0]                w_sum_word;
    logic                            w_cout;

    // A new request is taken whenever no operation is in flight.
    assign w_accept = bus.start && (r_state != ST_RUN);
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = w_run && (r_idx == IDX_W'(N_WORDS - 1));

    // Word-select mux feeding the adder.
    assign w_a_word = r_a_q[r_idx];
    assign w_b_word = r_b_q[r_idx];

    rca_seq_add_ctrl_rca_16_bit u_rca_16_bit (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_carry_q),
        .o_sum  (w_sum_word),
        .o_cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN lasts exactly N_WORDS cycles, DONE lasts one.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: w_state_next = bus.start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        w_busy = (r_state == ST_RUN);
        w_done = (r_state == ST_DONE);
    end

    // Operand capture, carry/index stepping and final flags.
    // Subtraction is a + ~b + 1: b is inverted on capture and the +1
    // enters as the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_carry_q <= 1'b0;
            r_idx     <= '0;
            r_c_out   <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a_q     <= bus.a;
            r_b_q     <= bus.sub ? ~bus.b : bus.b;
            r_carry_q <= bus.sub;
            r_idx     <= '0;
            r_c_out   <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_run) begin
            r_carry_q <= w_cout;
            if (w_last) begin
                // Hold idx on the last word so it never wraps.
                r_c_out <= w_cout;
                r_ovf   <= (r_a_q[N_WORDS-1][RCA_W-1] == r_b_q[N_WORDS-1][RCA_W-1]) &&
                           (w_sum_word[RCA_W-1] != r_a_q[N_WORDS-1][RCA_W-1]);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // One result register per word, written when its index is processed.
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_sum_word
        logic [RCA_W-1:0] r_word;

        // Cleared on reset and on a new request; loaded on its own RUN cycle.
        always_ff @(posedge clk) begin
            if (rst || w_accept) begin
                r_word <= '0;
            end else if (w_run && (r_idx == IDX_W'(gi))) begin
                r_word <= w_sum_word;
            end
        end

        assign w_sum_all[gi] = r_word;
    end

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.sum   = w_sum_all;
    assign bus.c_out = r_c_out;
    assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Directed + randomized bench for the 64-bit add/subtract sequencer.
module tb_rca_seq_add_ctrl;

    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_sum;
    logic        exp_c;
    logic        exp_o;

    rca_seq_add_ctrl_if #(.N_WORDS(NW)) bus_if ();

    rca_seq_add_ctrl #(.N_WORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Absolute guard against a hung run.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the full operands.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                  output logic [63:0] r, output logic c, output logic o);
        logic [64:0]        t;
        logic signed [65:0] sa, sb, sr;
        if (!s) begin
            t = {1'b0, a} + {1'b0, b};
            c = t[64];
        end else begin
            t = {1'b0, a} - {1'b0, b};
            c = (a >= b);
        end
        r  = t[63:0];
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        sr = s ? (sa - sb) : (sa + sb);
        o  = (sr[65:63] != 3'b000) && (sr[65:63] != 3'b111);
    endfunction

    // Issue one operation (called at posedge+1) and follow it to its done cycle.
    // glitch_at > 0 pulses start with junk operands during that RUN cycle.
    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input int glitch_at);
        int edges;
        int busy_n;
        model(a, b, s, exp_sum, exp_c, exp_o);
        bus_if.start = 1'b1;
        bus_if.sub   = s;
        bus_if.a     = a;
        bus_if.b     = b;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        bus_if.a     = ~a;
        bus_if.b     = ~b;
        bus_if.sub   = ~s;
        edges  = 1;
        busy_n = 0;
        while (bus_if.done !== 1'b1 && edges < 20) begin
            if (bus_if.busy === 1'b1) busy_n++;
            if (edges == glitch_at) begin
                bus_if.start = 1'b1;
                bus_if.a     = {$urandom, $urandom};
                bus_if.b     = {$urandom, $urandom};
            end else begin
                bus_if.start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, 64'(edges), 64'd5);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd4);
        check({tag, "_busy_in_done"}, 64'(bus_if.busy), 64'd0);
        check({tag, "_sum"}, bus_if.sum, exp_sum);
        check({tag, "_c_out"}, 64'(bus_if.c_out), 64'(exp_c));
        check({tag, "_ovf"}, 64'(bus_if.ovf), 64'(exp_o));
        $display("op %s a=%h b=%h sub=%0d -> sum=%h c=%0d ovf=%0d latency=%0d",
                 tag, a, b, s, bus_if.sum, bus_if.c_out, bus_if.ovf, edges);
    endtask

    // One idle cycle after done: pulse ends and the result holds.
    task automatic idle_hold(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus_if.done), 64'd0);
        check({tag, "_idle_busy"}, 64'(bus_if.busy), 64'd0);
        check({tag, "_hold_sum"}, bus_if.sum, exp_sum);
        check({tag, "_hold_c"}, 64'(bus_if.c_out), 64'(exp_c));
    endtask

    initial begin
        logic [63:0] ra, rb;
        int          done_seen;

        bus_if.start = 1'b0;
        bus_if.sub   = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus_if.busy), 64'd0);
        check("reset_done", 64'(bus_if.done), 64'd0);
        check("reset_sum", bus_if.sum, 64'd0);
        check("reset_c_out", 64'(bus_if.c_out), 64'd0);
        check("reset_ovf", 64'(bus_if.ovf), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        do_op("single_carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 0);
        check("single_carry_lit", bus_if.sum, 64'h0000_0000_0001_0000);
        idle_hold("single_carry");
        do_op("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        check("full_ripple_c", 64'(bus_if.c_out), 64'd1);
        idle_hold("full_ripple");
        do_op("sub_borrow", 64'd5, 64'd7, 1'b1, 0);
        check("sub_borrow_lit", bus_if.sum, 64'hFFFF_FFFF_FFFF_FFFE);
        idle_hold("sub_borrow");
        do_op("sub_noborrow", 64'd7, 64'd5, 1'b1, 0);
        check("sub_noborrow_c", 64'(bus_if.c_out), 64'd1);
        idle_hold("sub_noborrow");
        do_op("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        check("signed_ovf_flag", 64'(bus_if.ovf), 64'd1);
        idle_hold("signed_ovf");

        // Start during RUN is ignored; start during DONE chains with no gap.
        do_op("start_in_run", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 2);
        do_op("back_to_back", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 0);
        idle_hold("back_to_back");

        // Reset asserted for one edge in the third RUN cycle.
        bus_if.start = 1'b1;
        bus_if.sub   = 1'b0;
        bus_if.a     = 64'h1111_2222_3333_4444;
        bus_if.b     = 64'h0101_0202_0303_0404;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 64'(bus_if.busy), 64'd0);
        check("midrst_done", 64'(bus_if.done), 64'd0);
        check("midrst_sum", bus_if.sum, 64'd0);
        check("midrst_c_out", 64'(bus_if.c_out), 64'd0);
        done_seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus_if.done === 1'b1) done_seen++;
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        $display("op mid_reset busy=%0d done=%0d sum=%h done_after=%0d",
                 bus_if.busy, bus_if.done, bus_if.sum, done_seen);
        do_op("after_reset", 64'h1111_2222_3333_4444, 64'h0101_0202_0303_0404, 1'b0, 0);

        // Randomized operations with random gaps and occasional start-in-RUN.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1: ra = 64'h8000_0000_0000_0000;
                2: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                default: ra = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0: rb = 64'd1;
                1: rb = 64'h8000_0000_0000_0000;
                2: rb = 64'h0000_FFFF_0000_FFFF;
                default: rb = {$urandom, $urandom};
            endcase
            do_op($sformatf("rand%0d", n), ra, rb, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            if ($urandom_range(0, 2) != 0) idle_hold($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
